// File: rtl/rvsteel_mailbox.sv
// Memory-mapped mailbox: a CPU-to-peer TX FIFO and a peer-to-CPU RX FIFO,
// with status, sticky error flags and a level interrupt.
module rvsteel_mailbox #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] rw_address,
  output logic [31:0] read_data,
  input  logic        read_request,
  output logic        read_response,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_strobe,
  input  logic        write_request,
  output logic        write_response,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        irq
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_RXDATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_IRQ_EN = 2'd3;

  logic [31:0]      tx_mem [DEPTH];
  logic [31:0]      rx_mem [DEPTH];
  logic [PTR_W-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic [CNT_W-1:0] tx_count, rx_count;
  logic             tx_overflow, rx_underflow;
  logic [1:0]       irq_en;

  logic [1:0]  offset;
  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic        tx_write, tx_push, tx_pop, tx_overflow_set;
  logic        rx_read, rx_push, rx_pop, rx_underflow_set;
  logic        status_write, irq_en_write;
  logic [31:0] write_masked;
  logic [31:0] status_word;
  logic [31:0] read_data_c;
  logic        unused_address_bits;

  assign offset              = rw_address[3:2];
  assign unused_address_bits = ^{rw_address[31:4], rw_address[1:0]};

  // Full/empty come only from the registered counts.
  assign tx_full  = (tx_count == CNT_W'(DEPTH));
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == CNT_W'(DEPTH));
  assign rx_empty = (rx_count == '0);

  assign tx_valid = !tx_empty;
  assign tx_data  = tx_mem[tx_rd_ptr];
  assign rx_ready = !rx_full;

  assign write_masked = write_data & {{8{write_strobe[3]}}, {8{write_strobe[2]}},
                                      {8{write_strobe[1]}}, {8{write_strobe[0]}}};

  assign tx_write         = write_request && (offset == REG_TXDATA) && (write_strobe != 4'b0000);
  assign tx_push          = tx_write && !tx_full;
  assign tx_overflow_set  = tx_write && tx_full;
  assign tx_pop           = tx_valid && tx_ready;

  assign rx_read          = read_request && (offset == REG_RXDATA);
  assign rx_pop           = rx_read && !rx_empty;
  assign rx_underflow_set = rx_read && rx_empty;
  assign rx_push          = rx_valid && rx_ready;

  assign status_write = write_request && (offset == REG_STATUS) && write_strobe[0];
  assign irq_en_write = write_request && (offset == REG_IRQ_EN) && write_strobe[0];

  assign status_word = {8'b0, 8'(rx_count), 8'(tx_count), 2'b00,
                        rx_underflow, tx_overflow, rx_empty, rx_full, tx_empty, tx_full};

  always_comb begin
    read_data_c = '0;
    case (offset)
      REG_RXDATA: read_data_c = rx_empty ? 32'h0 : rx_mem[rx_rd_ptr];
      REG_STATUS: read_data_c = status_word;
      REG_IRQ_EN: read_data_c = {30'b0, irq_en};
      default:    read_data_c = '0;
    endcase
  end

  // FIFO storage is intentionally left out of reset.
  always_ff @(posedge clock) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= write_masked;
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_wr_ptr      <= '0;
      tx_rd_ptr      <= '0;
      rx_wr_ptr      <= '0;
      rx_rd_ptr      <= '0;
      tx_count       <= '0;
      rx_count       <= '0;
      tx_overflow    <= 1'b0;
      rx_underflow   <= 1'b0;
      irq_en         <= 2'b00;
      read_data      <= '0;
      read_response  <= 1'b0;
      write_response <= 1'b0;
      irq            <= 1'b0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_W'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_W'(1);
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_W'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_W'(1);
      tx_count <= tx_count + CNT_W'(tx_push) - CNT_W'(tx_pop);
      rx_count <= rx_count + CNT_W'(rx_push) - CNT_W'(rx_pop);

      // Sticky flags: a same-cycle set beats a write-1-to-clear.
      tx_overflow  <= tx_overflow_set  || (tx_overflow  && !(status_write && write_data[4]));
      rx_underflow <= rx_underflow_set || (rx_underflow && !(status_write && write_data[5]));

      if (irq_en_write) irq_en <= write_data[1:0];
      if (read_request) read_data <= read_data_c;
      read_response  <= read_request;
      write_response <= write_request;
      irq <= (irq_en[0] && !rx_empty) || (irq_en[1] && tx_empty);
    end
  end

endmodule

// File: tb/tb_rvsteel_mailbox.sv
// Directed bench for rvsteel_mailbox (DEPTH=8): bus handshake, both FIFOs,
// sticky flags, interrupt and reset behaviour.
module tb_rvsteel_mailbox;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] rw_address = '0;
  logic [31:0] read_data;
  logic        read_request = 1'b0;
  logic        read_response;
  logic [31:0] write_data = '0;
  logic [3:0]  write_strobe = '0;
  logic        write_request = 1'b0;
  logic        write_response;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [31:0] rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;

  rvsteel_mailbox #(.DEPTH(8)) dut (
    .clock(clock), .reset(reset), .rw_address(rw_address),
    .read_data(read_data), .read_request(read_request), .read_response(read_response),
    .write_data(write_data), .write_strobe(write_strobe), .write_request(write_request),
    .write_response(write_response), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .irq(irq)
  );

  always #5 clock = ~clock;

  localparam logic [1:0] TXDATA = 2'd0, RXDATA = 2'd1, STATUS = 2'd2, IRQ_EN = 2'd3;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cpu_write(input logic [1:0] off, input logic [31:0] d, input logic [3:0] s,
                           output logic resp);
    rw_address = {28'h0, off, 2'b00};
    write_data = d; write_strobe = s; write_request = 1'b1;
    tick();
    write_request = 1'b0;
    resp = write_response;
  endtask

  task automatic cpu_read(input logic [1:0] off, output logic [31:0] d, output logic resp);
    rw_address = {28'h0, off, 2'b00};
    read_request = 1'b1;
    tick();
    read_request = 1'b0;
    d = read_data;
    resp = read_response;
  endtask

  task automatic peer_push(input logic [31:0] d);
    rx_data = d; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic r;
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    vectors++; if (read_data !== 32'h0) begin miscompares++; $display("FAIL reset_read_data: got %h want 0", read_data); end
    vectors++; if ({read_response, write_response, irq} !== 3'b000) begin miscompares++; $display("FAIL reset_resp_irq: got %b want 000", {read_response, write_response, irq}); end
    vectors++; if ({tx_valid, rx_ready} !== 2'b01) begin miscompares++; $display("FAIL reset_peer: got %b want 01", {tx_valid, rx_ready}); end
    cpu_read(STATUS, d, r);
    vectors++; if ({r, d} !== {1'b1, 32'h0000000A}) begin miscompares++; $display("FAIL reset_status: got %b/%h want 1/0000000a", r, d); end
  endtask

  task automatic test_tx_push();
    logic [31:0] d; logic r;
    tx_ready = 1'b0;
    cpu_write(TXDATA, 32'hDEADBEEF, 4'b1111, r);
    vectors++; if (r !== 1'b1) begin miscompares++; $display("FAIL tx_wr_resp: got %b want 1", r); end
    tick();
    vectors++; if (write_response !== 1'b0) begin miscompares++; $display("FAIL tx_wr_resp_drop: got %b want 0", write_response); end
    vectors++; if ({tx_valid, tx_data} !== {1'b1, 32'hDEADBEEF}) begin miscompares++; $display("FAIL tx_head: got %b/%h want 1/deadbeef", tx_valid, tx_data); end
    cpu_read(STATUS, d, r);
    vectors++; if (d !== 32'h00000108) begin miscompares++; $display("FAIL tx_status1: got %h want 00000108", d); end
    cpu_write(TXDATA, 32'h11223344, 4'b0101, r);
    tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    vectors++; if ({tx_valid, tx_data} !== {1'b1, 32'h00220044}) begin miscompares++; $display("FAIL tx_strobe_mask: got %b/%h want 1/00220044", tx_valid, tx_data); end
    tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    cpu_write(TXDATA, 32'h12345678, 4'b0000, r);
    vectors++; if ({r, tx_valid} !== 2'b10) begin miscompares++; $display("FAIL tx_zero_strobe: got %b want 10", {r, tx_valid}); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d1, d2, d; logic r1, r2, r;
    peer_push(32'hA5A5A5A5);
    peer_push(32'h5A5A5A5A);
    rw_address = {28'h0, RXDATA, 2'b00};
    read_request = 1'b1;
    tick(); d1 = read_data; r1 = read_response;
    tick(); d2 = read_data; r2 = read_response;
    read_request = 1'b0;
    tick();
    vectors++; if ({r1, d1} !== {1'b1, 32'hA5A5A5A5}) begin miscompares++; $display("FAIL b2b_first: got %b/%h want 1/a5a5a5a5", r1, d1); end
    vectors++; if ({r2, d2} !== {1'b1, 32'h5A5A5A5A}) begin miscompares++; $display("FAIL b2b_second: got %b/%h want 1/5a5a5a5a", r2, d2); end
    vectors++; if ({read_response, read_data} !== {1'b0, 32'h5A5A5A5A}) begin miscompares++; $display("FAIL b2b_hold: got %b/%h want 0/5a5a5a5a", read_response, read_data); end
    cpu_read(STATUS, d, r);
    vectors++; if (d !== 32'h0000000A) begin miscompares++; $display("FAIL b2b_status: got %h want 0000000a", d); end
  endtask

  task automatic test_underflow();
    logic [31:0] d; logic r;
    cpu_read(RXDATA, d, r);
    vectors++; if ({r, d} !== {1'b1, 32'h0}) begin miscompares++; $display("FAIL uf_read: got %b/%h want 1/0", r, d); end
    // Read and write-1-to-clear on STATUS together: the read sees the old flag.
    rw_address = {28'h0, STATUS, 2'b00};
    write_data = 32'h20; write_strobe = 4'b0001;
    read_request = 1'b1; write_request = 1'b1;
    tick();
    read_request = 1'b0; write_request = 1'b0;
    vectors++; if ({read_response, write_response, read_data} !== {2'b11, 32'h0000002A}) begin miscompares++; $display("FAIL uf_status_rw: got %b%b/%h want 11/0000002a", read_response, write_response, read_data); end
    cpu_read(STATUS, d, r);
    vectors++; if (d !== 32'h0000000A) begin miscompares++; $display("FAIL uf_cleared: got %h want 0000000a", d); end
  endtask

  task automatic test_tx_overflow();
    logic [31:0] d; logic r;
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) cpu_write(TXDATA, 32'h100 + i, 4'b1111, r);
    cpu_read(STATUS, d, r);
    vectors++; if (d !== 32'h00000819) begin miscompares++; $display("FAIL ovf_status: got %h want 00000819", d); end
    for (int i = 0; i < 5; i++) begin
      vectors++; if ({tx_valid, tx_data} !== {1'b1, 32'h100 + i}) begin miscompares++; $display("FAIL ovf_drain%0d: got %b/%h want 1/%h", i, tx_valid, tx_data, 32'h100 + i); end
      tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    end
    for (int i = 0; i < 3; i++) cpu_write(TXDATA, 32'h200 + i, 4'b1111, r);
    for (int i = 0; i < 6; i++) begin
      d = (i < 3) ? 32'h105 + i : 32'h200 + i - 3;
      vectors++; if ({tx_valid, tx_data} !== {1'b1, d}) begin miscompares++; $display("FAIL wrap_drain%0d: got %b/%h want 1/%h", i, tx_valid, tx_data, d); end
      tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    end
    vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_empty: got %b want 0", tx_valid); end
    cpu_read(STATUS, d, r);
    vectors++; if (d !== 32'h0000001A) begin miscompares++; $display("FAIL ovf_sticky: got %h want 0000001a", d); end
    cpu_write(STATUS, 32'h10, 4'b0001, r);
    // Write to a full FIFO while the peer pops: still dropped.
    for (int i = 0; i < 8; i++) cpu_write(TXDATA, 32'h300 + i, 4'b1111, r);
    tx_ready = 1'b1;
    cpu_write(TXDATA, 32'h00000BAD, 4'b1111, r);
    tx_ready = 1'b0;
    cpu_read(STATUS, d, r);
    vectors++; if (d !== 32'h00000718) begin miscompares++; $display("FAIL ovf_with_pop: got %h want 00000718", d); end
    for (int i = 1; i < 8; i++) begin
      vectors++; if ({tx_valid, tx_data} !== {1'b1, 32'h300 + i}) begin miscompares++; $display("FAIL ovf_pop_drain%0d: got %b/%h want 1/%h", i, tx_valid, tx_data, 32'h300 + i); end
      tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    end
    cpu_write(STATUS, 32'h10, 4'b0001, r);
    cpu_read(STATUS, d, r);
    vectors++; if (d !== 32'h0000000A) begin miscompares++; $display("FAIL ovf_cleared: got %h want 0000000a", d); end
  endtask

  task automatic test_rx_full();
    logic [31:0] d; logic r;
    for (int i = 0; i < 8; i++) peer_push(32'h400 + i);
    vectors++; if (rx_ready !== 1'b0) begin miscompares++; $display("FAIL rx_full_ready: got %b want 0", rx_ready); end
    cpu_read(STATUS, d, r);
    vectors++; if (d !== 32'h00080006) begin miscompares++; $display("FAIL rx_full_status: got %h want 00080006", d); end
    rx_data = 32'hFFFF0000; rx_valid = 1'b1;
    cpu_read(RXDATA, d, r);
    rx_valid = 1'b0;
    vectors++; if ({r, d} !== {1'b1, 32'h400}) begin miscompares++; $display("FAIL rx_full_pop: got %b/%h want 1/00000400", r, d); end
    cpu_read(STATUS, d, r);
    vectors++; if (d !== 32'h00070002) begin miscompares++; $display("FAIL rx_full_refused: got %h want 00070002", d); end
    rx_data = 32'h500; rx_valid = 1'b1;
    cpu_read(RXDATA, d, r);
    rx_valid = 1'b0;
    vectors++; if (d !== 32'h401) begin miscompares++; $display("FAIL rx_pushpop_data: got %h want 00000401", d); end
    cpu_read(STATUS, d, r);
    vectors++; if (d !== 32'h00070002) begin miscompares++; $display("FAIL rx_pushpop_count: got %h want 00070002", d); end
    for (int i = 0; i < 7; i++) begin
      cpu_read(RXDATA, d, r);
      vectors++; if (d !== ((i < 6) ? 32'h402 + i : 32'h500)) begin miscompares++; $display("FAIL rx_drain%0d: got %h want %h", i, d, (i < 6) ? 32'h402 + i : 32'h500); end
    end
    rx_data = 32'h600; rx_valid = 1'b1;
    cpu_read(RXDATA, d, r);
    rx_valid = 1'b0;
    vectors++; if ({r, d} !== {1'b1, 32'h0}) begin miscompares++; $display("FAIL rx_empty_pushpop: got %b/%h want 1/0", r, d); end
    cpu_read(STATUS, d, r);
    vectors++; if (d !== 32'h00010022) begin miscompares++; $display("FAIL rx_empty_pushpop_status: got %h want 00010022", d); end
    cpu_read(RXDATA, d, r);
    vectors++; if (d !== 32'h600) begin miscompares++; $display("FAIL rx_stored_word: got %h want 00000600", d); end
    cpu_write(STATUS, 32'h20, 4'b0001, r);
  endtask

  task automatic test_irq();
    logic [31:0] d; logic r;
    cpu_write(IRQ_EN, 32'hFFFFFFF1, 4'b0001, r);
    cpu_read(IRQ_EN, d, r);
    vectors++; if (d !== 32'h1) begin miscompares++; $display("FAIL irq_en_read: got %h want 00000001", d); end
    tick();
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_idle: got %b want 0", irq); end
    peer_push(32'h77);
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_push_edge: got %b want 0", irq); end
    tick();
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_rise: got %b want 1", irq); end
    cpu_read(RXDATA, d, r);
    vectors++; if ({irq, d} !== {1'b1, 32'h77}) begin miscompares++; $display("FAIL irq_pop: got %b/%h want 1/00000077", irq, d); end
    tick();
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_fall: got %b want 0", irq); end
    cpu_write(IRQ_EN, 32'h2, 4'b0010, r);
    cpu_read(IRQ_EN, d, r);
    vectors++; if (d !== 32'h1) begin miscompares++; $display("FAIL irq_en_strobe: got %h want 00000001", d); end
    cpu_write(IRQ_EN, 32'h3, 4'b0001, r);
    peer_push(32'h88);
    tick();
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_tx_empty: got %b want 1", irq); end
    // Reset lands in the same cycle as a read request.
    rw_address = {28'h0, STATUS, 2'b00};
    read_request = 1'b1; reset = 1'b1;
    tick();
    read_request = 1'b0; reset = 1'b0;
    vectors++; if ({read_response, irq, read_data} !== {2'b00, 32'h0}) begin miscompares++; $display("FAIL rst_mid_read: got %b%b/%h want 00/0", read_response, irq, read_data); end
    vectors++; if ({tx_valid, rx_ready} !== 2'b01) begin miscompares++; $display("FAIL rst_mid_peer: got %b want 01", {tx_valid, rx_ready}); end
    tick();
    vectors++; if ({read_response, irq} !== 2'b00) begin miscompares++; $display("FAIL rst_no_late_resp: got %b want 00", {read_response, irq}); end
    cpu_read(STATUS, d, r);
    vectors++; if (d !== 32'h0000000A) begin miscompares++; $display("FAIL rst_status: got %h want 0000000a", d); end
    cpu_read(IRQ_EN, d, r);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL rst_irq_en: got %h want 0", d); end
  endtask

  initial begin
    test_reset();
    test_tx_push();
    test_back_to_back();
    test_underflow();
    test_tx_overflow();
    test_rx_full();
    test_irq();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
